uart_tx: RTL and testbench

Serial transmitter for the CPU's `OUTA` path: accepts one byte per `transmit` pulse and shifts it out on `tx` as an 8N1 (or 8N2) asynchronous frame, LSB first. It sits between the CPU (`tx_byte`, `transmit`, `is_transmitting`) and the board's UART TX pin, alongside the receiver feeding `rx_byte`/`received`. The CPU polls `is_transmitting` low, then pulses `transmit` for exactly one cycle with `tx_byte` valid.

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter (8 data bits, no parity,
// 1 or 2 stop bits, LSB first).
//
// The CPU waits for is_transmitting low, then pulses transmit for one cycle
// with tx_byte valid. The byte is captured on that edge and shifted out on tx.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit period (>= 2)
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   tx_byte [7:0]   in   byte to send, sampled only when transmit is accepted
//   transmit        in   one-cycle send request; ignored while busy
//   is_transmitting out  high for every cycle of a frame
//   tx_done         out  high on the last cycle of the final stop bit
//   tx              out  serial line (registered), idles high
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       transmit,
    output logic       is_transmitting,
    output logic       tx_done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA   = 3'd7;
    localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_reg, state_next;
    logic [7:0]     shift_reg, shift_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]  baud_reg, baud_next;
    logic           tx_reg, tx_next;

    logic           baud_end;

    assign baud_end = (baud_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            baud_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            baud_reg    <= baud_next;
            tx_reg      <= tx_next;
        end
    end

    // tx_next is the line level for the coming cycle, so it is derived from
    // the state being entered, keeping the pin a pure flop output.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        baud_next    = baud_reg;
        tx_next      = tx_reg;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (transmit) begin
                    shift_next   = tx_byte;
                    bit_cnt_next = '0;
                    baud_next    = BAUD_RELOAD;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end

            START: begin
                if (baud_end) begin
                    baud_next  = BAUD_RELOAD;
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_cnt_reg == LAST_DATA) begin
                        // bit counter is reused to count stop bits
                        bit_cnt_next = '0;
                        tx_next      = 1'b1;
                        state_next   = STOP;
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        bit_cnt_next = '0;
                        shift_next   = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        baud_next    = BAUD_RELOAD;
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx              = tx_reg;
    assign is_transmitting = (state_reg != IDLE);
    assign tx_done         = (state_reg == STOP) && baud_end && (bit_cnt_reg == LAST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// dut1: CLKS_PER_BIT=4, STOP_BITS=1;  dut2: CLKS_PER_BIT=4, STOP_BITS=2.
// Outputs are sampled on the falling clock edge; sample k is cycle T0+k where
// T0 is the rising edge that accepted transmit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte1 = '0, tx_byte2 = '0;
    logic       transmit1 = 1'b0, transmit2 = 1'b0;
    logic       busy1, done1, txl1;
    logic       busy2, done2, txl2;

    int checks = 0;
    int passes = 0;

    logic cap_tx   [0:255];
    logic cap_busy [0:255];
    logic cap_done [0:255];
    logic [7:0] dec_q [$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_byte(tx_byte1), .transmit(transmit1),
        .is_transmitting(busy1), .tx_done(done1), .tx(txl1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_byte(tx_byte2), .transmit(transmit2),
        .is_transmitting(busy2), .tx_done(done2), .tx(txl2)
    );

    // ---------------- reference model ----------------
    // Expected {tx, busy, done} at cycle k after acceptance of b0 at cycle 0,
    // optionally followed by b1 accepted at the end of cycle t1 (t1 <= 0: none).
    function automatic logic [2:0] model(int k, int stops, logic [7:0] b0,
                                         int t1, logic [7:0] b1);
        int rel, flen, idx;
        logic [7:0] b;
        logic bitv;
        rel  = k;
        b    = b0;
        if (t1 > 0 && k > t1) begin
            rel = k - t1;
            b   = b1;
        end
        flen = (9 + stops) * CPB;
        if (rel < 1 || rel > flen) return 3'b100;
        idx = (rel - 1) / CPB;
        if (idx == 0)      bitv = 1'b0;
        else if (idx <= 8) bitv = b[idx-1];
        else               bitv = 1'b1;
        return {bitv, 1'b1, (rel == flen)};
    endfunction

    function automatic int wave_err(int n, int stops, logic [7:0] b0,
                                    int t1, logic [7:0] b1);
        int e = 0;
        for (int k = 1; k <= n; k++)
            if ({cap_tx[k], cap_busy[k], cap_done[k]} !== model(k, stops, b0, t1, b1))
                e++;
        return e;
    endfunction

    function automatic int count_busy(int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cap_busy[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done(int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cap_done[k] === 1'b1) c++;
        return c;
    endfunction

    // Line receiver: find a start edge, sample each bit mid-period.
    function automatic void decode(int n);
        int k, s;
        logic [7:0] b;
        dec_q.delete();
        k = 1;
        while (k <= n) begin
            if (cap_tx[k] === 1'b0) begin
                s = k;
                if (s + 9 * CPB + CPB / 2 > n) break;
                for (int i = 0; i < 8; i++) b[i] = cap_tx[s + (i + 1) * CPB + CPB / 2];
                dec_q.push_back(b);
                k = s + 9 * CPB;
            end else begin
                k++;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input int which, input logic [7:0] b);
        @(negedge clk);
        if (which == 1) begin tx_byte1 = b; transmit1 = 1'b1; end
        else            begin tx_byte2 = b; transmit2 = 1'b1; end
        @(posedge clk);
        #1;
        transmit1 = 1'b0;
        transmit2 = 1'b0;
        $display("send dut%0d byte 0x%02h at %0t", which, b, $time);
    endtask

    // Record n samples; tx_byte is scrambled every cycle, and a transmit
    // pulse with byte pb is raised during cycles p1 and p2 (0 = none).
    task automatic capture(input int which, input int n, input int p1,
                           input int p2, input logic [7:0] pb);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_tx[k]   = (which == 1) ? txl1  : txl2;
            cap_busy[k] = (which == 1) ? busy1 : busy2;
            cap_done[k] = (which == 1) ? done1 : done2;
            transmit1 = 1'b0;
            transmit2 = 1'b0;
            tx_byte1  = 8'($urandom);
            tx_byte2  = 8'($urandom);
            if (k == p1 || k == p2) begin
                if (which == 1) begin tx_byte1 = pb; transmit1 = 1'b1; end
                else            begin tx_byte2 = pb; transmit2 = 1'b1; end
            end
        end
        transmit1 = 1'b0;
        transmit2 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int bad;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({txl1, busy1, done1, txl2, busy2, done2} !== 6'b100100)
            $display("FAIL reset_async: got %b want 100100",
                     {txl1, busy1, done1, txl2, busy2, done2});
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        capture(1, 100, 0, 0, 8'h00);
        bad = 0;
        for (int k = 1; k <= 100; k++)
            if (cap_tx[k] !== 1'b1 || cap_busy[k] !== 1'b0 || cap_done[k] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) $display("FAIL reset_idle: %0d bad cycles, want 0", bad);
        else passes++;
        $display("reset/idle checked");
    endtask

    task automatic test_single_55;
        logic [9:0] want_bits;
        logic [9:0] got_bits;
        int e;
        want_bits = 10'b1010101010; // index 0 = start bit
        send(1, 8'h55);
        capture(1, 50, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) got_bits[i] = cap_tx[1 + i * CPB + CPB / 2];
        checks++;
        if (got_bits !== want_bits) $display("FAIL s55_bits: got %b want %b", got_bits, want_bits);
        else passes++;
        e = wave_err(50, 1, 8'h55, 0, 8'h00);
        checks++;
        if (e !== 0) $display("FAIL s55_wave: %0d mismatched cycles, want 0", e);
        else passes++;
        checks++;
        if (count_busy(50) !== 40) $display("FAIL s55_busy: got %0d want 40", count_busy(50));
        else passes++;
        checks++;
        if (count_done(50) !== 1 || cap_done[40] !== 1'b1)
            $display("FAIL s55_done: count %0d, cyc40 %b want 1/1", count_done(50), cap_done[40]);
        else passes++;
    endtask

    task automatic test_stop2_a3;
        logic [10:0] want_bits;
        logic [10:0] got_bits;
        int e;
        want_bits = 11'b11101000110; // start 0, 1,1,0,0,0,1,0,1, stop 1,1
        send(2, 8'hA3);
        capture(2, 55, 0, 0, 8'h00);
        for (int i = 0; i < 11; i++) got_bits[i] = cap_tx[1 + i * CPB + CPB / 2];
        checks++;
        if (got_bits !== want_bits) $display("FAIL a3_bits: got %b want %b", got_bits, want_bits);
        else passes++;
        e = wave_err(55, 2, 8'hA3, 0, 8'h00);
        checks++;
        if (e !== 0) $display("FAIL a3_wave: %0d mismatched cycles, want 0", e);
        else passes++;
        checks++;
        if (count_busy(55) !== 44) $display("FAIL a3_busy: got %0d want 44", count_busy(55));
        else passes++;
        decode(55);
        checks++;
        if (dec_q.size() !== 1 || dec_q[0] !== 8'hA3)
            $display("FAIL a3_decode: got %0d frames first 0x%02h want 1 x 0xa3",
                     dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'h00);
        else passes++;
    endtask

    task automatic test_busy_ignore;
        int e;
        send(1, 8'h0F);
        capture(1, 80, 10, 38, 8'hFF);
        e = wave_err(80, 1, 8'h0F, 0, 8'h00);
        checks++;
        if (e !== 0) $display("FAIL ignore_wave: %0d mismatched cycles, want 0", e);
        else passes++;
        checks++;
        if (count_done(80) !== 1) $display("FAIL ignore_done: got %0d want 1", count_done(80));
        else passes++;
        decode(80);
        checks++;
        if (dec_q.size() !== 1 || dec_q[0] !== 8'h0F)
            $display("FAIL ignore_decode: got %0d frames first 0x%02h want 1 x 0x0f",
                     dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'h00);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int e;
        send(1, 8'h12);
        // cycle 41 is the first cycle with is_transmitting low
        capture(1, 90, 41, 0, 8'h34);
        checks++;
        if (cap_busy[41] !== 1'b0 || cap_tx[41] !== 1'b1 || cap_busy[42] !== 1'b1 || cap_tx[42] !== 1'b0)
            $display("FAIL b2b_gap: busy41 %b tx41 %b busy42 %b tx42 %b want 0 1 1 0",
                     cap_busy[41], cap_tx[41], cap_busy[42], cap_tx[42]);
        else passes++;
        e = wave_err(90, 1, 8'h12, 41, 8'h34);
        checks++;
        if (e !== 0) $display("FAIL b2b_wave: %0d mismatched cycles, want 0", e);
        else passes++;
        decode(90);
        checks++;
        if (dec_q.size() !== 2 || dec_q[0] !== 8'h12 || dec_q[1] !== 8'h34)
            $display("FAIL b2b_decode: got %0d frames want 2 (0x12, 0x34)", dec_q.size());
        else passes++;
    endtask

    task automatic test_reset_midframe;
        int e;
        send(1, 8'h00);
        capture(1, 18, 0, 0, 8'h00); // inside data bit 3 (cycles 17..20)
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({txl1, busy1, done1} !== 3'b100)
            $display("FAIL midrst_async: got %b want 100", {txl1, busy1, done1});
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        capture(1, 60, 0, 0, 8'h00);
        checks++;
        if (count_done(60) !== 0 || count_busy(60) !== 0)
            $display("FAIL midrst_quiet: done %0d busy %0d want 0 0", count_done(60), count_busy(60));
        else passes++;
        send(1, 8'h81);
        capture(1, 50, 0, 0, 8'h00);
        e = wave_err(50, 1, 8'h81, 0, 8'h00);
        checks++;
        if (e !== 0) $display("FAIL midrst_next: %0d mismatched cycles, want 0", e);
        else passes++;
    endtask

    task automatic test_random;
        logic [7:0] b;
        int e;
        for (int i = 0; i < 6; i++) begin
            int which;
            int stops;
            which = (i % 2) + 1;
            stops = which;
            b = 8'($urandom);
            send(which, b);
            capture(which, 60, $urandom_range(2, 30), 0, 8'($urandom));
            e = wave_err(60, stops, b, 0, 8'h00);
            checks++;
            if (e !== 0) $display("FAIL rand_wave%0d: %0d mismatched cycles, byte 0x%02h, want 0", i, e, b);
            else passes++;
            decode(60);
            checks++;
            if (dec_q.size() !== 1 || dec_q[0] !== b)
                $display("FAIL rand_decode%0d: got %0d frames first 0x%02h want 0x%02h",
                         i, dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'h00, b);
            else passes++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_55();
        test_stop2_a3();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
